// File: rtl/femto8_pkg.sv
// Shared constants and types for the femto8 UART transmitter slice.
package femto8_pkg;

  localparam logic [7:0] TX_ADDR_DEF   = 8'h0F;
  localparam logic [7:0] STAT_ADDR_DEF = 8'h0E;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;
  localparam int unsigned ST_EMPTY = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/femto8_fifo.sv
// Synchronous FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module femto8_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/femto8_uart_tx.sv
// Memory-mapped 8N1 transmitter: CPU stores to TX_ADDR are queued and shifted out on txd.
module femto8_uart_tx
  import femto8_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  TX_ADDR      = TX_ADDR_DEF,
  parameter logic [7:0]  STAT_ADDR    = STAT_ADDR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic [7:0] rdata,
  output logic       sel,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;

  logic        push_req, clr_req, pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic        unused_fifo_count;
  logic        baud_done;
  logic [7:0]  status;

  assign push_req  = write && (address == TX_ADDR);
  assign clr_req   = write && (address == STAT_ADDR);
  assign baud_done = (baud_q == BAUD_TC);
  assign unused_fifo_count = ^fifo_count;

  femto8_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rdata;
          bit_d   = '0;
          baud_d  = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_rdata;
            bit_d   = '0;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // txd is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = sh_d[0];
      default:  txd_d = 1'b1;
    endcase

    if (push_req && fifo_full) ovf_d = 1'b1;
    else if (clr_req)          ovf_d = 1'b0;
    else                       ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign txd  = txd_q;
  assign busy = !fifo_empty || (state_q != TX_IDLE);
  assign sel  = (address == STAT_ADDR);

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf_q;
    status[ST_EMPTY] = fifo_empty;
  end

  assign rdata = sel ? status : '0;

endmodule

// File: tb/tb_femto8_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes and start cycles, a UART receiver model checks txd.
module tb_femto8_uart_tx;

  localparam logic [7:0] TXA = 8'h0F;
  localparam logic [7:0] STA = 8'h0E;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       write = 1'b0;
  logic [7:0] rdata;
  logic       sel, txd, busy;

  femto8_uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4),
    .TX_ADDR      (8'h0F),
    .STAT_ADDR    (8'h0E)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .wdata   (wdata),
    .write   (write),
    .rdata   (rdata),
    .sel     (sel),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   last_exp = -1000;

  // A single address bus cannot hit the transmit and status registers on the same edge.
  always @(posedge clk) begin
    if (write) assert (!(address == TXA && address == STA));
  end

  // Receiver model: samples mid-bit on falling clock edges.
  logic       m_active = 1'b0;
  int         m_cnt;
  int         m_start;
  logic [7:0] m_byte;
  logic       m_start_ok;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (txd == 1'b0) begin
        m_active   = 1'b1;
        m_cnt      = 0;
        m_start    = cyc;
        m_byte     = 8'h00;
        m_start_ok = 1'b1;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 2) begin
        m_start_ok = (txd == 1'b0);
      end else if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt % 4) == 2) begin
        m_byte = {txd, m_byte[7:1]};
      end else if (m_cnt == 38) begin
        m_active = 1'b0;
        chk("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("rx_data", m_byte, m_e.data);
          chk("start_cycle", m_start, m_e.start);
          chk("framing", {m_start_ok, txd}, 2'b11);
        end
      end
    end
  end

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    write   = 1'b1;
    @(negedge clk);
    write   = 1'b0;
    address = 8'h00;
    wdata   = 8'h00;
  endtask

  task automatic send(input logic [7:0] d);
    exp_t e;
    int   c;
    c       = cyc;
    e.data  = d;
    e.start = (c + 2 > last_exp + 40) ? c + 2 : last_exp + 40;
    last_exp = e.start;
    sb.push_back(e);
    cpu_write(TXA, d);
  endtask

  task automatic rd_status(input string name, input logic [7:0] a,
                           input logic exp_sel, input logic [7:0] exp_rd);
    address = a;
    #1;
    chk({name, "_sel"}, sel, exp_sel);
    chk(name, rdata, exp_rd);
    address = 8'h00;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int c0, s0;

  initial begin
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    rd_status("rst_stat", STA, 1'b1, 8'h08);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    rd_status("idle_stat", STA, 1'b1, 8'h08);
    rd_status("other_addr", 8'h0D, 1'b0, 8'h00);

    // Single byte
    c0 = cyc;
    send(8'hA5);
    wait_cyc(c0 + 2 + 39);
    chk("single_busy_last", busy, 1);
    @(negedge clk);
    chk("single_busy_done", busy, 0);
    chk("single_txd_idle", txd, 1);
    repeat (5) @(negedge clk);

    // Back-to-back frames
    c0 = cyc;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    wait_cyc(c0 + 2 + 119);
    chk("b2b_busy_last", busy, 1);
    @(negedge clk);
    chk("b2b_busy_done", busy, 0);
    repeat (3) @(negedge clk);

    // Overflow: one popped, four buffered, sixth dropped
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    cpu_write(TXA, 8'h66);
    rd_status("ovf_stat", STA, 1'b1, 8'h07);
    cpu_write(STA, 8'h00);
    rd_status("ovf_clr_stat", STA, 1'b1, 8'h03);
    wait_cyc(last_exp + 41);
    chk("drain_busy", busy, 0);
    rd_status("drain_stat", STA, 1'b1, 8'h08);

    // Reset during DATA bit 3
    c0 = cyc;
    send(8'hF0);
    cpu_write(TXA, 8'h77);
    s0 = c0 + 2;
    wait_cyc(s0 + 17);
    chk("mid_txd_bit3", txd, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_txd_async", txd, 1);
    chk("mid_busy_rst", busy, 0);
    sb.delete();
    last_exp = -1000;
    rd_status("mid_rst_stat", STA, 1'b1, 8'h08);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    rd_status("post_rst_stat", STA, 1'b1, 8'h08);
    repeat (50) @(negedge clk);

    // Ignored write
    cpu_write(8'h05, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      chk("ign_busy", busy, 0);
      @(negedge clk);
    end
    rd_status("ign_stat", STA, 1'b1, 8'h08);
    repeat (50) @(negedge clk);
    chk("ign_txd", txd, 1);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/femto8_uart_tx.md
# femto8_uart_tx

Memory-mapped serial transmitter on the femto8 CPU data bus, downstream of the CPU store path. It consumes CPU writes to a fixed low address, buffers bytes in a small FIFO, and shifts them out as 8N1 frames on `txd`. It also returns a status byte combinationally for CPU `read [B]` accesses to its status address.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..255.
- `FIFO_DEPTH`, 4: entries; power of two, 2..16.
- `TX_ADDR`, 8'h0F: write target for transmit data.
- `STAT_ADDR`, 8'h0E: status register address. A read returns status; a write clears overflow.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: reset, **asynchronous, active-low** (0 = reset).
- `address` in 8: CPU address bus.
- `wdata` in 8: CPU `data_out`.
- `write` in 1: CPU write strobe.
- `rdata` out 8: status byte; combinational, valid when `sel`=1, otherwise 8'h00.
- `sel` out 1: combinational, 1 when `address == STAT_ADDR`. Top level muxes `rdata` into CPU `data_in`.
- `txd` out 1: serial output; idle high.
- `busy` out 1: 1 while the FIFO is non-empty or the shifter is not IDLE.

## Operation
- Push: on a clock edge with `write`=1 and `address==TX_ADDR`, `wdata` is written to the FIFO tail.
  - If the FIFO was full before that edge, the byte is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle.
- Clear: on an edge with `write`=1 and `address==STAT_ADDR`, `overflow` is cleared.
  - If a push overflow occurs on that same edge, set takes priority. This cannot happen with a single address bus; a bench assertion covers it.
- Writes to any other address are ignored. Repeated strobes are counted per cycle; the CPU holds `write` for exactly one cycle per store.
- Status byte: bit0 = `busy`, bit1 = FIFO full, bit2 = `overflow`, bit3 = FIFO empty, bits 7:4 = 0.
- Shifter FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into shift register `sh`, clear the bit counter and baud counter, then go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `txd`=`sh[0]`, LSB first. Every `CLKS_PER_BIT` cycles, shift right and increment the bit index. After 8 bits, go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, and the bit period ends on the terminal count. Width is `$clog2(CLKS_PER_BIT)`; it never wraps mid-bit.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.
- Reset mid-frame: the frame is abandoned, `txd` goes to 1 immediately (asynchronously), and the FIFO is emptied.

## Timing
- Reset values:
  - `txd`=1, `busy`=0, `overflow`=0.
  - FIFO empty, FSM in IDLE, all counters 0.
  - `rdata`/`sel` follow `address` combinationally; in reset, `rdata` reads 8'h08 at `STAT_ADDR`.
- Latency: a push at edge E0 makes the FIFO non-empty after E0. IDLE pops at E1, so `txd` falls after E1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles from the falling start edge to the next START or IDLE.
- `busy` rises after the push edge. It falls after the edge that leaves STOP with the FIFO empty.
- A pop and a push on the same edge with the FIFO non-full both take effect; the count is unchanged.

## Structure
- Shared package `femto8_pkg`:
  - default `TX_ADDR`/`STAT_ADDR` constants
  - status bit index constants
  - shifter state enum (2-bit)
- Sub-module `femto8_fifo`: synchronous FIFO with parameterized width/depth, push/pop, full/empty/count, and async active-low reset. The top level instantiates it and contains the shifter FSM, baud counter and status decode.

## Test plan
Bench uses `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- Single byte: write 8'hA5 to 8'h0F → `txd` falls 1 cycle later and holds 4 cycles each for the sequence 0,1,0,1,0,0,1,0,1, then stop=1; `busy` low after 40 cycles.
- Back-to-back: write 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames with no idle cycles between stop and start; total 120 cycles.
- Overflow: six writes on consecutive cycles while the first frame starts → 5 accepted (1 popped plus 4 buffered), 6th dropped; a status read gives bit2=1, bit1=1. Writing 8'h00 to 8'h0E clears bit2.
- Status decode: `address`=8'h0E in idle → `sel`=1, `rdata`=8'h08; `address`=8'h0D → `sel`=0, `rdata`=8'h00.
- Reset mid-frame: assert `reset`=0 during DATA bit 3 → `txd`=1 asynchronously; after release, `busy`=0 and the FIFO is empty.
- Ignored writes: write to 8'h05 → no frame, `busy` stays 0.
